// File: rtl/fdk_regfile.sv
// Parameterised register bank for the FDK access types RW, RO, WO, RW2C and RW2S.
// Single-outstanding req/ack host bus; hardware side supplies RO data and set/clear events.
module fdk_regfile #(
  parameter int unsigned NREG   = 8,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = (NREG > 1) ? $clog2(NREG) : 1,
  parameter logic [NREG*DATA_W-1:0] RESET_VAL = '0,
  parameter logic [NREG*DATA_W-1:0] RO_MASK   = '0,
  parameter logic [NREG*DATA_W-1:0] WO_MASK   = '0,
  parameter logic [NREG*DATA_W-1:0] RW2C_MASK = '0,
  parameter logic [NREG*DATA_W-1:0] RW2S_MASK = '0,
  parameter logic [NREG*DATA_W-1:0] IRQ_MASK  = '0
) (
  input  logic                     sysclk,
  input  logic                     sysrst_n,
  input  logic                     reg_rd,
  input  logic                     reg_wr,
  input  logic [ADDR_W-1:0]        reg_addr,
  input  logic [DATA_W-1:0]        reg_wdata,
  input  logic [DATA_W/8-1:0]      reg_be,
  output logic                     reg_ack,
  output logic [DATA_W-1:0]        reg_rdata,
  output logic                     reg_err,
  input  logic [NREG*DATA_W-1:0]   hw_rdata,
  input  logic [NREG*DATA_W-1:0]   hw_set,
  input  logic [NREG*DATA_W-1:0]   hw_clr,
  output logic [NREG*DATA_W-1:0]   reg_q,
  output logic [NREG-1:0]          wr_pulse,
  output logic                     irq
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned NSLOT = 1 << ADDR_W;

  // Configuration sanity, caught at elaboration.
  if (((RO_MASK & WO_MASK) | (RO_MASK & RW2C_MASK) | (RO_MASK & RW2S_MASK) |
       (WO_MASK & RW2C_MASK) | (WO_MASK & RW2S_MASK) | (RW2C_MASK & RW2S_MASK)) != '0)
  begin : g_mask_overlap
    $error("fdk_regfile: access-type masks overlap");
  end
  if ((DATA_W % 8) != 0 || DATA_W == 0) begin : g_bad_width
    $error("fdk_regfile: DATA_W must be a non-zero multiple of 8");
  end
  if (NREG < 2 || NREG > 256 || NSLOT < NREG) begin : g_bad_depth
    $error("fdk_regfile: NREG out of range or ADDR_W too narrow");
  end

  typedef enum logic {ST_IDLE, ST_ACK} state_e;

  state_e                   state_q, state_d;
  logic                     accept, bad, do_wr, do_rd;
  logic                     ack_d, err_d, irq_d;
  logic [DATA_W-1:0]        rdata_d;
  logic [NREG-1:0]          pulse_d;
  logic [DATA_W-1:0]        be_bits;
  logic [NREG*DATA_W-1:0]   store_flat;
  logic [DATA_W-1:0]       rview [NSLOT];

  for (genvar g = 0; g < BE_W; g++) begin : g_be
    assign be_bits[g*8 +: 8] = {8{reg_be[g]}};
  end

  // Next-state and request decode; all bus outputs are registered from the _d values.
  always_comb begin : fsm_next
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (reg_rd || reg_wr) begin
          accept  = 1'b1;
          state_d = ST_ACK;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
    endcase
    bad     = accept && ((32'(reg_addr) >= NREG) || (reg_rd && reg_wr));
    do_wr   = accept && reg_wr && !bad;
    do_rd   = accept && reg_rd && !bad;
    ack_d   = accept;
    err_d   = bad;
    rdata_d = do_rd ? rview[reg_addr] : '0;
    irq_d   = |(store_flat & RW2C_MASK & IRQ_MASK);
  end

  always_ff @(posedge sysclk or negedge sysrst_n) begin : fsm_state
    if (!sysrst_n) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  always_ff @(posedge sysclk or negedge sysrst_n) begin : out_regs
    if (!sysrst_n) begin
      reg_ack   <= 1'b0;
      reg_rdata <= '0;
      reg_err   <= 1'b0;
      wr_pulse  <= '0;
      irq       <= 1'b0;
    end else begin
      reg_ack   <= ack_d;
      reg_rdata <= rdata_d;
      reg_err   <= err_d;
      wr_pulse  <= pulse_d;
      irq       <= irq_d;
    end
  end

  // Per-register storage; RO positions are never stored so reg_q shows them as 0.
  for (genvar r = 0; r < NREG; r++) begin : g_reg
    localparam logic [DATA_W-1:0] RO_R  = RO_MASK[r*DATA_W +: DATA_W];
    localparam logic [DATA_W-1:0] WO_R  = WO_MASK[r*DATA_W +: DATA_W];
    localparam logic [DATA_W-1:0] C_R   = RW2C_MASK[r*DATA_W +: DATA_W];
    localparam logic [DATA_W-1:0] S_R   = RW2S_MASK[r*DATA_W +: DATA_W];
    localparam logic [DATA_W-1:0] PL_R  = ~(RO_R | C_R | S_R);
    localparam logic [DATA_W-1:0] RST_R = RESET_VAL[r*DATA_W +: DATA_W] & ~RO_R;

    logic              sel;
    logic [DATA_W-1:0] m, sw1, q, d;

    assign sel = do_wr && (reg_addr == ADDR_W'(r));
    assign m   = sel ? be_bits : '0;
    assign sw1 = m & reg_wdata;

    // hw_set beats a software clear; a software set beats hw_clr.
    assign d = (PL_R & ((q & ~m) | sw1))
             | (C_R  & ((q & ~sw1) | hw_set[r*DATA_W +: DATA_W]))
             | (S_R  & ((q & ~hw_clr[r*DATA_W +: DATA_W]) | sw1));

    always_ff @(posedge sysclk or negedge sysrst_n) begin : store
      if (!sysrst_n) q <= RST_R;
      else           q <= d;
    end

    assign store_flat[r*DATA_W +: DATA_W] = q;
    assign rview[r]   = (q & ~(RO_R | WO_R)) | (hw_rdata[r*DATA_W +: DATA_W] & RO_R);
    assign pulse_d[r] = sel;
  end

  for (genvar a = NREG; a < NSLOT; a++) begin : g_pad
    assign rview[a] = '0;
  end

  assign reg_q = store_flat;

endmodule

// File: tb/tb_fdk_regfile.sv
// Directed scoreboard bench for fdk_regfile: NREG=4, reg1 RW, reg2 RW2C, reg3 mixed types.
module tb_fdk_regfile;

  localparam int unsigned NREG   = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 3;

  localparam logic [127:0] RO_M  = {32'h0000FF00, 96'h0};
  localparam logic [127:0] WO_M  = {32'h00FF0000, 96'h0};
  localparam logic [127:0] S_M   = {32'h000000FF, 96'h0};
  localparam logic [127:0] C_M   = {32'h0, 32'hFFFFFFFF, 64'h0};
  localparam logic [127:0] IRQ_M = {32'h0, 32'h00000001, 64'h0};

  logic          sysclk, sysrst_n;
  logic          reg_rd, reg_wr;
  logic [2:0]    reg_addr;
  logic [31:0]   reg_wdata;
  logic [3:0]    reg_be;
  logic          reg_ack, reg_err, irq;
  logic [31:0]   reg_rdata;
  logic [127:0]  hw_rdata, hw_set, hw_clr, reg_q;
  logic [3:0]    wr_pulse;

  fdk_regfile #(
    .NREG(NREG), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
    .RESET_VAL('0), .RO_MASK(RO_M), .WO_MASK(WO_M),
    .RW2C_MASK(C_M), .RW2S_MASK(S_M), .IRQ_MASK(IRQ_M)
  ) dut (
    .sysclk(sysclk), .sysrst_n(sysrst_n),
    .reg_rd(reg_rd), .reg_wr(reg_wr), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_be(reg_be),
    .reg_ack(reg_ack), .reg_rdata(reg_rdata), .reg_err(reg_err),
    .hw_rdata(hw_rdata), .hw_set(hw_set), .hw_clr(hw_clr),
    .reg_q(reg_q), .wr_pulse(wr_pulse), .irq(irq)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  pulse;
  } exp_t;

  exp_t         sb[$];
  int           n_checks = 0;
  int           n_pass   = 0;
  logic [127:0] exp_q    = '0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Compare one completed access against the oldest scoreboard entry.
  task automatic pop_cmp(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 128'(1), 128'(0));
    end else begin
      e = sb.pop_front();
      chk({tag, "_rdata"}, 128'(reg_rdata), 128'(e.rdata));
      chk({tag, "_err"},   128'(reg_err),   128'(e.err));
      chk({tag, "_pulse"}, 128'(wr_pulse),  128'(e.pulse));
    end
  endtask

  task automatic access(input logic rd, input logic wr, input logic [2:0] addr,
                        input logic [31:0] wd, input logic [3:0] be,
                        input logic [31:0] erd, input logic eerr, input logic [3:0] ep,
                        input string tag);
    int n;
    sb.push_back('{rdata: erd, err: eerr, pulse: ep});
    @(negedge sysclk);
    reg_rd = rd; reg_wr = wr; reg_addr = addr; reg_wdata = wd; reg_be = be;
    @(posedge sysclk); #1;
    reg_rd = 1'b0; reg_wr = 1'b0; hw_set = '0; hw_clr = '0;
    n = 0;
    while (reg_ack !== 1'b1 && n < 5) begin
      @(posedge sysclk); #1;
      n++;
    end
    chk({tag, "_lat"}, 128'(n), 128'(0));
    if (reg_ack === 1'b1) pop_cmp(tag);
    else void'(sb.pop_front());
    @(posedge sysclk); #1;
    chk({tag, "_ack_end"}, 128'(reg_ack), 128'(0));
  endtask

  initial begin
    sysrst_n = 1'b0;
    reg_rd = 1'b0; reg_wr = 1'b0; reg_addr = '0; reg_wdata = '0; reg_be = '0;
    hw_set = '0; hw_clr = '0;
    hw_rdata = {32'h12345A78, 96'hFFFFFFFF_FFFFFFFF_FFFFFFFF};
    repeat (2) @(posedge sysclk);
    #1;
    chk("rst_ack",   128'(reg_ack),   128'(0));
    chk("rst_rdata", 128'(reg_rdata), 128'(0));
    chk("rst_err",   128'(reg_err),   128'(0));
    chk("rst_pulse", 128'(wr_pulse),  128'(0));
    chk("rst_irq",   128'(irq),       128'(0));
    chk("rst_q",     reg_q,           128'(0));
    @(negedge sysclk) sysrst_n = 1'b1;

    // Byte-enabled RW write then read back.
    access(1'b0, 1'b1, 3'd1, 32'hDEADBEEF, 4'b0101, 32'h0, 1'b0, 4'b0010, "wr1");
    exp_q[63:32] = 32'h00AD00EF;
    chk("wr1_q", reg_q, exp_q);
    access(1'b1, 1'b0, 3'd1, 32'h0, 4'h0, 32'h00AD00EF, 1'b0, 4'b0000, "rd1");

    // RW2C event: irq two edges after hw_set.
    @(negedge sysclk) hw_set[64] = 1'b1;
    @(posedge sysclk); #1;
    hw_set = '0;
    chk("set_irq_e1", 128'(irq), 128'(0));
    exp_q[64] = 1'b1;
    chk("set_q", reg_q, exp_q);
    @(posedge sysclk); #1;
    chk("set_irq_e2", 128'(irq), 128'(1));

    // Software clear racing a new event: event wins.
    hw_set[64] = 1'b1;
    access(1'b0, 1'b1, 3'd2, 32'h1, 4'hF, 32'h0, 1'b0, 4'b0100, "w2c_race");
    chk("w2c_race_q",   reg_q,     exp_q);
    chk("w2c_race_irq", 128'(irq), 128'(1));

    access(1'b0, 1'b1, 3'd2, 32'h1, 4'hF, 32'h0, 1'b0, 4'b0100, "w2c_clr");
    exp_q[64] = 1'b0;
    chk("w2c_clr_q",   reg_q,     exp_q);
    chk("w2c_clr_irq", 128'(irq), 128'(0));

    // Mixed-type register 3.
    access(1'b0, 1'b1, 3'd3, 32'h00FFFFFF, 4'hF, 32'h0, 1'b0, 4'b1000, "wr3");
    exp_q[127:96] = 32'h00FF00FF;
    chk("wr3_q", reg_q, exp_q);
    access(1'b1, 1'b0, 3'd3, 32'h0, 4'h0, 32'h00005AFF, 1'b0, 4'b0000, "rd3");

    hw_clr[103:96] = 8'hFF;
    access(1'b0, 1'b1, 3'd3, 32'h00000001, 4'hF, 32'h0, 1'b0, 4'b1000, "w2s_race");
    exp_q[127:96] = 32'h00000001;
    chk("w2s_race_q", reg_q, exp_q);
    access(1'b1, 1'b0, 3'd3, 32'h0, 4'h0, 32'h00005A01, 1'b0, 4'b0000, "rd3b");

    // Error accesses leave storage untouched.
    access(1'b1, 1'b0, 3'd5, 32'h0, 4'h0, 32'h0, 1'b1, 4'b0000, "bad_rd");
    chk("bad_rd_q", reg_q, exp_q);
    access(1'b0, 1'b1, 3'd7, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1, 4'b0000, "bad_wr");
    chk("bad_wr_q", reg_q, exp_q);
    access(1'b1, 1'b1, 3'd0, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1, 4'b0000, "rd_wr");
    chk("rd_wr_q", reg_q, exp_q);

    // Reset asserted in the ack cycle of an accepted write.
    @(negedge sysclk);
    reg_wr = 1'b1; reg_addr = 3'd1; reg_wdata = 32'h12345678; reg_be = 4'hF;
    @(posedge sysclk); #1;
    sysrst_n = 1'b0; reg_wr = 1'b0;
    #1;
    exp_q = '0;
    chk("mid_rst_ack",   128'(reg_ack),   128'(0));
    chk("mid_rst_pulse", 128'(wr_pulse),  128'(0));
    chk("mid_rst_rdata", 128'(reg_rdata), 128'(0));
    chk("mid_rst_q",     reg_q,           exp_q);
    @(posedge sysclk); #1;
    chk("mid_rst_ack2", 128'(reg_ack), 128'(0));
    @(negedge sysclk) sysrst_n = 1'b1;

    // Held read: accepted every other edge.
    access(1'b0, 1'b1, 3'd0, 32'hA5A50F0F, 4'hF, 32'h0, 1'b0, 4'b0001, "wr0");
    exp_q[31:0] = 32'hA5A50F0F;
    chk("wr0_q", reg_q, exp_q);
    sb.push_back('{rdata: 32'hA5A50F0F, err: 1'b0, pulse: 4'b0000});
    sb.push_back('{rdata: 32'hA5A50F0F, err: 1'b0, pulse: 4'b0000});
    @(negedge sysclk);
    reg_rd = 1'b1; reg_addr = 3'd0;
    for (int i = 0; i < 4; i++) begin
      @(posedge sysclk); #1;
      if (i == 3) reg_rd = 1'b0;
      chk($sformatf("held_ack%0d", i), 128'(reg_ack), 128'((i % 2) == 0));
      if (reg_ack === 1'b1) pop_cmp($sformatf("held%0d", i));
    end
    chk("held_sb_left", 128'(sb.size()), 128'(0));
    @(posedge sysclk); #1;
    chk("held_idle", 128'(reg_ack), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
